// File: rtl/game_sequencer.sv
// Memory-game round controller: load a pattern, play it back on the LED,
// collect the player's bits under a timeout, then judge and track the level.
module game_sequencer #(
   parameter int PATTERN_W     = 16,
   parameter int MAX_LEVEL     = 15,
   parameter int TICK_DIV      = 25000000,
   parameter int TIMEOUT_TICKS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 go,
   input  logic [PATTERN_W-1:0] pattern_in,
   input  logic                 resp_valid,
   input  logic                 resp_bit,
   output logic [3:0]           level,
   output logic                 show_en,
   output logic                 show_bit,
   output logic                 resp_ok,
   output logic                 busy,
   output logic [1:0]           result,
   output logic [3:0]           state_code
);

   localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);

   localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICK_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(1);
   localparam logic [TICK_W-1:0] TICK_ZERO   = TICK_W'(0);
   localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_TICKS - 1);
   localparam logic [TO_W-1:0]   TO_ONE      = TO_W'(1);
   localparam logic [TO_W-1:0]   TO_ZERO     = TO_W'(0);
   localparam logic [3:0]        LEVEL_MAX   = 4'(MAX_LEVEL);

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_LOAD = 4'd1,
      ST_SHOW = 4'd2,
      ST_RESP = 4'd3,
      ST_PASS = 4'd4,
      ST_FAIL = 4'd5,
      ST_WIN  = 4'd6
   } state_t;

   state_t               state_r;
   logic [PATTERN_W-1:0] shreg_r;
   logic [PATTERN_W-1:0] pat_copy_r;
   logic [3:0]           step_r;
   logic [3:0]           level_r;
   logic [1:0]           result_r;
   logic                 resp_ok_r;
   logic [TICK_W-1:0]    tick_cnt_r;
   logic [TO_W-1:0]      to_cnt_r;

   logic                 tick_s;
   logic                 resp_match_s;

   assign tick_s       = (tick_cnt_r == TICK_ZERO);
   assign resp_match_s = (resp_bit == shreg_r[PATTERN_W-1]);

   // All outputs come straight from registers or from a decode of the state register.
   assign level      = level_r;
   assign result     = result_r;
   assign resp_ok    = resp_ok_r;
   assign state_code = state_r;
   assign show_en    = (state_r == ST_SHOW);
   assign show_bit   = (state_r == ST_SHOW) & shreg_r[PATTERN_W-1];
   assign busy       = (state_r != ST_IDLE);

   // Round FSM with playback pacing, response checking and timeout counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         shreg_r    <= {PATTERN_W{1'b0}};
         pat_copy_r <= {PATTERN_W{1'b0}};
         step_r     <= 4'd0;
         level_r    <= 4'd0;
         result_r   <= 2'd0;
         resp_ok_r  <= 1'b0;
         tick_cnt_r <= TICK_ZERO;
         to_cnt_r   <= TO_ZERO;
      end else begin
         resp_ok_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (go) state_r <= ST_LOAD;
               else    state_r <= ST_IDLE;
            end
            ST_LOAD: begin
               pat_copy_r <= pattern_in;
               shreg_r    <= pattern_in;
               step_r     <= 4'd0;
               tick_cnt_r <= TICK_RELOAD;
               result_r   <= 2'd0;
               state_r    <= ST_SHOW;
            end
            ST_SHOW: begin
               if (tick_s) begin
                  tick_cnt_r <= TICK_RELOAD;
                  if (step_r == level_r) begin
                     // Rewind so the response phase compares against the same bits.
                     shreg_r  <= pat_copy_r;
                     step_r   <= 4'd0;
                     to_cnt_r <= TO_ZERO;
                     state_r  <= ST_RESP;
                  end else begin
                     shreg_r <= {shreg_r[PATTERN_W-2:0], 1'b0};
                     step_r  <= step_r + 4'd1;
                  end
               end else begin
                  tick_cnt_r <= tick_cnt_r - TICK_ONE;
               end
            end
            ST_RESP: begin
               // A response takes priority over a timeout tick in the same cycle.
               if (resp_valid) begin
                  if (!resp_match_s) begin
                     state_r <= ST_FAIL;
                  end else begin
                     resp_ok_r  <= 1'b1;
                     shreg_r    <= {shreg_r[PATTERN_W-2:0], 1'b0};
                     tick_cnt_r <= TICK_RELOAD;
                     to_cnt_r   <= TO_ZERO;
                     if (step_r == level_r) state_r <= ST_PASS;
                     else                   step_r  <= step_r + 4'd1;
                  end
               end else if (tick_s) begin
                  tick_cnt_r <= TICK_RELOAD;
                  if (to_cnt_r == TO_LAST) state_r  <= ST_FAIL;
                  else                     to_cnt_r <= to_cnt_r + TO_ONE;
               end else begin
                  tick_cnt_r <= tick_cnt_r - TICK_ONE;
               end
            end
            ST_PASS: begin
               if (level_r == LEVEL_MAX) begin
                  state_r <= ST_WIN;
               end else begin
                  level_r  <= level_r + 4'd1;
                  result_r <= 2'd1;
                  state_r  <= ST_IDLE;
               end
            end
            ST_FAIL: begin
               level_r  <= 4'd0;
               result_r <= 2'd2;
               state_r  <= ST_IDLE;
            end
            ST_WIN: begin
               level_r  <= 4'd0;
               result_r <= 2'd3;
               state_r  <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a fast tick (TICK_DIV=4) and 8-tick timeout.
module tb_game_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        go;
   logic [15:0] pattern_in;
   logic        resp_valid;
   logic        resp_bit;
   logic [3:0]  level;
   logic        show_en;
   logic        show_bit;
   logic        resp_ok;
   logic        busy;
   logic [1:0]  result;
   logic [3:0]  state_code;

   int n_cmp = 0;
   int n_err = 0;

   game_sequencer #(
      .PATTERN_W(16), .MAX_LEVEL(15), .TICK_DIV(4), .TIMEOUT_TICKS(8)
   ) dut (
      .clk(clk), .reset(reset), .go(go), .pattern_in(pattern_in),
      .resp_valid(resp_valid), .resp_bit(resp_bit), .level(level),
      .show_en(show_en), .show_bit(show_bit), .resp_ok(resp_ok),
      .busy(busy), .result(result), .state_code(state_code)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic wait_state(input logic [3:0] code, input int limit);
      int n = 0;
      while (state_code !== code && n < limit) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (state_code !== code) begin n_err++; $display("FAIL wait_state: state_code=%0d required %0d within %0d cycles", state_code, code, limit); end
   endtask

   task automatic respond(input logic b);
      resp_valid = 1'b1;
      resp_bit   = b;
      @(negedge clk);
      resp_valid = 1'b0;
      resp_bit   = 1'b0;
   endtask

   task automatic pass_round(input logic [15:0] pat, input int nbits);
      pattern_in = pat;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      wait_state(4'd3, 100);
      for (int i = 0; i < nbits; i++) respond(pat[15-i]);
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1; go = 1'b0; pattern_in = 16'h0000; resp_valid = 1'b0; resp_bit = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (state_code !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_code); end
      n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
      n_cmp++; if ({show_en, show_bit, resp_ok, busy} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {show_en, show_bit, resp_ok, busy}); end
      n_cmp++; if (result !== 2'd0) begin n_err++; $display("FAIL reset_result: got %0d want 0", result); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_level0_pass;
      pattern_in = 16'h8000; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      n_cmp++; if (state_code !== 4'd1) begin n_err++; $display("FAIL l0_load: got %0d want 1", state_code); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++; if ({state_code, show_en, show_bit} !== {4'd2, 1'b1, 1'b1}) begin n_err++; $display("FAIL l0_show[%0d]: got state=%0d en=%b bit=%b want 2 1 1", i, state_code, show_en, show_bit); end
      end
      @(negedge clk);
      n_cmp++; if ({state_code, show_en} !== {4'd3, 1'b0}) begin n_err++; $display("FAIL l0_resp: got state=%0d en=%b want 3 0", state_code, show_en); end
      respond(1'b1);
      n_cmp++; if ({state_code, resp_ok} !== {4'd4, 1'b1}) begin n_err++; $display("FAIL l0_pass: got state=%0d ok=%b want 4 1", state_code, resp_ok); end
      @(negedge clk);
      n_cmp++; if ({state_code, result, level, resp_ok, busy} !== {4'd0, 2'd1, 4'd1, 1'b0, 1'b0}) begin n_err++; $display("FAIL l0_done: got state=%0d result=%0d level=%0d ok=%b busy=%b want 0 1 1 0 0", state_code, result, level, resp_ok, busy); end
   endtask

   task automatic test_level2_playback;
      logic [15:0] pat_ref;
      pat_ref = 16'hA000;
      pass_round(16'h4000, 2);
      n_cmp++; if (level !== 4'd2) begin n_err++; $display("FAIL l1_level: got %0d want 2", level); end
      pattern_in = pat_ref; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      n_cmp++; if (state_code !== 4'd1) begin n_err++; $display("FAIL l2_load: got %0d want 1", state_code); end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) pattern_in = 16'h0000;
         n_cmp++; if ({show_en, show_bit} !== {1'b1, pat_ref[15 - i/4]}) begin n_err++; $display("FAIL l2_show[%0d]: got en=%b bit=%b want 1 %b", i, show_en, show_bit, pat_ref[15 - i/4]); end
      end
      @(negedge clk);
      n_cmp++; if ({state_code, show_en, show_bit} !== {4'd3, 1'b0, 1'b0}) begin n_err++; $display("FAIL l2_resp: got state=%0d en=%b bit=%b want 3 0 0", state_code, show_en, show_bit); end
      respond(1'b1);
      n_cmp++; if (resp_ok !== 1'b1) begin n_err++; $display("FAIL l2_ok0: got %b want 1", resp_ok); end
      respond(1'b0);
      n_cmp++; if (resp_ok !== 1'b1) begin n_err++; $display("FAIL l2_ok1: got %b want 1", resp_ok); end
      respond(1'b1);
      n_cmp++; if ({state_code, resp_ok} !== {4'd4, 1'b1}) begin n_err++; $display("FAIL l2_ok2: got state=%0d ok=%b want 4 1", state_code, resp_ok); end
      @(negedge clk);
      n_cmp++; if ({state_code, result, level} !== {4'd0, 2'd1, 4'd3}) begin n_err++; $display("FAIL l2_done: got state=%0d result=%0d level=%0d want 0 1 3", state_code, result, level); end
   endtask

   task automatic test_reset_mid_show;
      pattern_in = 16'hF000; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      wait_state(4'd2, 10);
      repeat (2) @(negedge clk);
      n_cmp++; if ({level, show_en} !== {4'd3, 1'b1}) begin n_err++; $display("FAIL rst_pre: got level=%0d en=%b want 3 1", level, show_en); end
      reset = 1'b1;
      #1;
      n_cmp++; if ({state_code, level, show_en, show_bit, busy, result, resp_ok} !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}) begin n_err++; $display("FAIL rst_mid: got state=%0d level=%0d en=%b bit=%b busy=%b result=%0d ok=%b want all 0", state_code, level, show_en, show_bit, busy, result, resp_ok); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mismatch;
      pass_round(16'h8000, 1);
      pass_round(16'h4000, 2);
      n_cmp++; if (level !== 4'd2) begin n_err++; $display("FAIL mm_level: got %0d want 2", level); end
      pattern_in = 16'hA000; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      wait_state(4'd3, 100);
      respond(1'b1);
      n_cmp++; if ({state_code, resp_ok} !== {4'd3, 1'b1}) begin n_err++; $display("FAIL mm_first: got state=%0d ok=%b want 3 1", state_code, resp_ok); end
      respond(1'b1);
      n_cmp++; if ({state_code, resp_ok} !== {4'd5, 1'b0}) begin n_err++; $display("FAIL mm_wrong: got state=%0d ok=%b want 5 0", state_code, resp_ok); end
      @(negedge clk);
      n_cmp++; if ({state_code, result, level} !== {4'd0, 2'd2, 4'd0}) begin n_err++; $display("FAIL mm_done: got state=%0d result=%0d level=%0d want 0 2 0", state_code, result, level); end
   endtask

   task automatic test_timeout;
      pattern_in = 16'h8000; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      wait_state(4'd3, 100);
      for (int k = 2; k <= 32; k++) @(negedge clk);
      n_cmp++; if (state_code !== 4'd3) begin n_err++; $display("FAIL to_cycle32: got %0d want 3", state_code); end
      @(negedge clk);
      n_cmp++; if (state_code !== 4'd5) begin n_err++; $display("FAIL to_fail: got %0d want 5", state_code); end
      @(negedge clk);
      n_cmp++; if ({state_code, result, level} !== {4'd0, 2'd2, 4'd0}) begin n_err++; $display("FAIL to_done: got state=%0d result=%0d level=%0d want 0 2 0", state_code, result, level); end
   endtask

   task automatic test_timeout_restart(input int resp_cycle);
      pass_round(16'h8000, 1);
      pattern_in = 16'hC000; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      wait_state(4'd3, 100);
      for (int k = 1; k <= resp_cycle + 33; k++) begin
         if (k > 1) @(negedge clk);
         if (k == resp_cycle) begin resp_valid = 1'b1; resp_bit = 1'b1; end
         if (k == resp_cycle + 1) begin
            resp_valid = 1'b0; resp_bit = 1'b0;
            n_cmp++; if ({state_code, resp_ok} !== {4'd3, 1'b1}) begin n_err++; $display("FAIL tr%0d_ok: got state=%0d ok=%b want 3 1", resp_cycle, state_code, resp_ok); end
         end
         if (k == 33 || k == resp_cycle + 32) begin
            n_cmp++; if (state_code !== 4'd3) begin n_err++; $display("FAIL tr%0d_alive@%0d: got %0d want 3", resp_cycle, k, state_code); end
         end
         if (k == resp_cycle + 33) begin
            n_cmp++; if (state_code !== 4'd5) begin n_err++; $display("FAIL tr%0d_fail: got %0d want 5", resp_cycle, state_code); end
         end
      end
      @(negedge clk);
      n_cmp++; if ({state_code, result, level} !== {4'd0, 2'd2, 4'd0}) begin n_err++; $display("FAIL tr%0d_done: got state=%0d result=%0d level=%0d want 0 2 0", resp_cycle, state_code, result, level); end
   endtask

   task automatic test_win;
      for (int l = 0; l < 15; l++) pass_round(16'hFFFF, l + 1);
      n_cmp++; if ({level, result} !== {4'd15, 2'd1}) begin n_err++; $display("FAIL win_pre: got level=%0d result=%0d want 15 1", level, result); end
      pattern_in = 16'hFFFF; go = 1'b1;
      @(negedge clk);
      wait_state(4'd3, 200);
      for (int i = 0; i < 16; i++) respond(1'b1);
      n_cmp++; if (state_code !== 4'd4) begin n_err++; $display("FAIL win_pass: got %0d want 4", state_code); end
      @(negedge clk);
      n_cmp++; if (state_code !== 4'd6) begin n_err++; $display("FAIL win_state: got %0d want 6", state_code); end
      @(negedge clk);
      n_cmp++; if ({state_code, result, level} !== {4'd0, 2'd3, 4'd0}) begin n_err++; $display("FAIL win_done: got state=%0d result=%0d level=%0d want 0 3 0", state_code, result, level); end
      @(negedge clk);
      n_cmp++; if ({state_code, busy} !== {4'd1, 1'b1}) begin n_err++; $display("FAIL win_restart: got state=%0d busy=%b want 1 1", state_code, busy); end
      go = 1'b0;
   endtask

   initial begin
      test_reset();
      test_level0_pass();
      test_level2_playback();
      test_reset_mid_show();
      test_mismatch();
      test_timeout();
      test_timeout_restart(30);
      test_timeout_restart(32);
      test_win();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Round controller for the memory game: sequences one round as load pattern -> play back pattern -> collect player response -> judge.
- Owns level tracking, playback pacing (internal rate divider) and response timeout.
- Sits between the top-level switch/key inputs and the pattern source (level ROM/shifter). Drives LED playback and the HEX state display.

Parameters:
- PATTERN_W, 16, pattern width in bits. Playback is MSB first. Level port width is 4, so PATTERN_W <= 16.
- MAX_LEVEL, 15, highest level. A round at level L plays L+1 bits. Must be <= PATTERN_W-1.
- TICK_DIV, 25000000, clk cycles per playback step and per timeout tick. Must be >= 2.
- TIMEOUT_TICKS, 8, ticks allowed in RESP with no response before the round fails.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- go  in  1  level-sensitive start request; sampled only in IDLE
- pattern_in  in  PATTERN_W  pattern for the current level; sampled in LOAD
- resp_valid  in  1  single-cycle pulse: player entered one bit
- resp_bit  in  1  player's bit, qualified by resp_valid
- level  out  4  current level, 0..MAX_LEVEL
- show_en  out  1  high throughout SHOW
- show_bit  out  1  bit currently played back; 0 when show_en=0
- resp_ok  out  1  one-cycle pulse for each correct response bit
- busy  out  1  high in every state except IDLE
- result  out  2  last round outcome: 0 none, 1 pass, 2 fail, 3 win
- state_code  out  4  IDLE=0, LOAD=1, SHOW=2, RESP=3, PASS=4, FAIL=5, WIN=6

Behaviour:
- Reset (async, any state, including mid-round):
  - state=IDLE; level, result, shift/copy registers, step count, tick and timeout counters all 0.
  - All outputs 0.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.
- IDLE:
  - go=1 -> LOAD on the next edge.
  - resp_valid ignored. result holds the last outcome.
- LOAD (1 cycle):
  - pat_copy <= pattern_in; shreg <= pattern_in.
  - step <= 0; tick counter <= TICK_DIV-1; result <= 0.
  - Next state: SHOW.
- SHOW:
  - show_en=1, show_bit=shreg[PATTERN_W-1].
  - Tick counter decrements every cycle; tick asserts when counter==0, then reloads TICK_DIV-1. Each bit is therefore held exactly TICK_DIV cycles.
  - On a tick with step<level: shreg shifts left by 1, step++.
  - On a tick with step==level: shreg <= pat_copy, step <= 0, tick counter reloaded, timeout counter <= 0, go to RESP.
  - resp_valid ignored.
- RESP:
  - On resp_valid:
    - Compare resp_bit with shreg[MSB].
    - Mismatch -> FAIL.
    - Match -> resp_ok pulse; shreg shifts; tick and timeout counters reset.
    - If step==level -> PASS, else step++.
  - Each tick with no response: timeout counter++. Reaching TIMEOUT_TICKS -> FAIL.
  - resp_valid on the same cycle as the timeout-reaching tick: the response wins; no timeout that cycle.
- PASS (1 cycle):
  - If level==MAX_LEVEL -> WIN.
  - Else level++, result <= 1, go to IDLE.
- FAIL (1 cycle): level <= 0, result <= 2, go to IDLE.
- WIN (1 cycle): level <= 0, result <= 3, go to IDLE.
- Round restart: go still high on return to IDLE starts the next round immediately; no edge detection.
- Width rules:
  - step is 4 bits and never exceeds level.
  - level saturates via the WIN path and never wraps.
- Latency:
  - go high in IDLE -> LOAD next cycle -> show_en high two cycles after go was sampled.
  - SHOW lasts (level+1)*TICK_DIV cycles.
  - Final correct response -> PASS next cycle -> IDLE with result visible the cycle after.
- pattern_in changes after LOAD have no effect on the round in progress.

Test Plan:
- Reset: assert reset mid-SHOW at level 3 -> same cycle state_code=0, level=0, show_en=0, busy=0, result=0.
- Level 0 pass (TICK_DIV=4, pattern 16'h8000):
  - Stimulus: go pulse.
  - Required: LOAD for 1 cycle; show_bit=1 for 4 cycles; RESP.
  - Then resp_valid with bit 1 -> resp_ok pulse, PASS, result=1, level=1.
- Level 2 playback (pattern 16'hA000) -> show_bit sequence 1,0,1, each held 4 cycles, show_en high for 12 cycles. Responses 1,0,1 -> result=1, level=3.
- Mismatch: level 2, responses 1,1 -> FAIL after the second response, result=2, level=0, no resp_ok on the wrong bit.
- Timeout (TICK_DIV=4, TIMEOUT_TICKS=8): no response in RESP -> FAIL after 32 cycles, result=2. A response at cycle 30 restarts the count: no FAIL until 32 cycles after it.
- Win: preload level=MAX_LEVEL via passes, complete a correct round -> WIN, result=3, level=0. go held high -> a new LOAD follows IDLE immediately.
